// File: rtl/bip_control_unit.sv
// bip_control_unit: multi-cycle fetch/decode/execute control unit for the BIP accumulator processor
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-high reset
//   i_start             one-cycle pulse that leaves IDLE
//   i_instruction       synchronous program memory data, valid the cycle after o_pc
//   o_pc                program memory address
//   o_operand           operand field: data RAM address or immediate
//   o_sel_a             accumulator mux: 00 RAM, 01 immediate, 10 adder/subtractor
//   o_sel_b, o_op       adder/subtractor B select (0 RAM, 1 imm) and op (0 ADD, 1 SUB)
//   o_wr_acc            accumulator load enable
//   o_rd_ram, o_wr_ram  data RAM read / write strobes
//   o_halt              high while halted
//   o_cycle_count       saturating count of clocks spent in FETCH/DECODE/EXEC
module bip_control_unit #(
    parameter int NBITS         = 16,
    parameter int NBITS_OPCODE  = 5,
    parameter int NBITS_OPERAND = 11,
    parameter int NBITS_PC      = 11,
    parameter int NBITS_CNT     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [NBITS-1:0]         i_instruction,
    output logic [NBITS_PC-1:0]      o_pc,
    output logic [NBITS_OPERAND-1:0] o_operand,
    output logic [1:0]               o_sel_a,
    output logic                     o_sel_b,
    output logic                     o_op,
    output logic                     o_wr_acc,
    output logic                     o_rd_ram,
    output logic                     o_wr_ram,
    output logic                     o_halt,
    output logic [NBITS_CNT-1:0]     o_cycle_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
    state_t state, state_next;
    logic [NBITS-1:0] ir;
    logic [NBITS_OPCODE-1:0] opc, new_opc;
    logic [1:0] sel_a_q;
    logic sel_b_q, op_q;
    logic exec, is_ld, is_ldi, is_alu, running;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            ir            <= '0;
            o_pc          <= '0;
            sel_a_q       <= '0;
            sel_b_q       <= 1'b0;
            op_q          <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            state   <= state_next;
            sel_a_q <= o_sel_a;
            sel_b_q <= o_sel_b;
            op_q    <= o_op;
            if (state == DECODE) ir <= i_instruction;
            if (exec && opc != '0) o_pc <= o_pc + 1'b1;
            if (running && o_cycle_count != '1) o_cycle_count <= o_cycle_count + 1'b1;
        end
    end
    // Strobes decode from state so an asynchronous reset drops them at once;
    // mux selects fall back to their held copies outside the EXEC that sets them.
    always_comb begin
        opc        = ir[NBITS-1 -: NBITS_OPCODE];
        new_opc    = i_instruction[NBITS-1 -: NBITS_OPCODE];
        exec       = state == EXEC;
        running    = state == FETCH || state == DECODE || exec;
        is_ld      = opc == NBITS_OPCODE'(2);
        is_ldi     = opc == NBITS_OPCODE'(3);
        is_alu     = opc >= NBITS_OPCODE'(4) && opc <= NBITS_OPCODE'(7);
        state_next = state == IDLE   ? (i_start ? FETCH : IDLE)
                   : state == FETCH  ? DECODE
                   : state == DECODE ? EXEC
                   : exec            ? (opc == '0 ? HALT : FETCH)
                   : HALT;
        // The instruction register loads at the end of DECODE, so DECODE
        // itself looks straight at the memory data.
        o_operand  = state == DECODE ? i_instruction[NBITS_OPERAND-1:0] : ir[NBITS_OPERAND-1:0];
        o_rd_ram   = state == DECODE && (new_opc == NBITS_OPCODE'(2) || new_opc == NBITS_OPCODE'(4)
                                         || new_opc == NBITS_OPCODE'(6));
        o_wr_ram   = exec && opc == NBITS_OPCODE'(1);
        o_wr_acc   = exec && (is_ld || is_ldi || is_alu);
        o_sel_a    = exec && is_ld ? 2'b00 : exec && is_ldi ? 2'b01 : exec && is_alu ? 2'b10 : sel_a_q;
        o_sel_b    = exec && is_alu ? opc[0] : sel_b_q;
        o_op       = exec && is_alu ? opc[1] : op_q;
        o_halt     = state == HALT;
    end
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: directed table-driven and sequence checks of bip_control_unit
module tb_bip_control_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] instr = '0;
    logic [10:0] pc, operand;
    logic [1:0]  sel_a;
    logic        sel_b, op, wr_acc, rd_ram, wr_ram, halt;
    logic [31:0] cnt;
    logic [15:0] mem [0:2047];
    int n_vec = 0;
    int n_err = 0;
    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [6:0]  dec;
        logic [6:0]  exe;
        logic        hlt;
    } vec_t;
    vec_t vecs [10];
    bip_control_unit dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_instruction(instr),
        .o_pc(pc), .o_operand(operand), .o_sel_a(sel_a), .o_sel_b(sel_b), .o_op(op),
        .o_wr_acc(wr_acc), .o_rd_ram(rd_ram), .o_wr_ram(wr_ram), .o_halt(halt),
        .o_cycle_count(cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) instr <= mem[pc];
    function automatic logic [6:0] strb();
        return {wr_acc, wr_ram, rd_ram, sel_a, sel_b, op};
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_mem(input logic [15:0] fill);
        for (int i = 0; i < 2048; i++) mem[i] = fill;
    endtask
    task automatic reset_and_start();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    // Starts in FETCH, checks DECODE and EXEC, ends in the following state.
    task automatic run_instr(input string name, input logic [6:0] dec, input logic [6:0] exe);
        tick();
        check({name, " decode"}, 32'(strb()), 32'(dec));
        tick();
        check({name, " exec"}, 32'(strb()), 32'(exe));
        tick();
    endtask
    initial begin
        vecs[0] = '{"HLT",  16'h0000, 7'b000_00_0_0, 7'b000_00_0_0, 1'b1};
        vecs[1] = '{"STO",  16'h0810, 7'b000_00_0_0, 7'b010_00_0_0, 1'b0};
        vecs[2] = '{"LD",   16'h1004, 7'b001_00_0_0, 7'b100_00_0_0, 1'b0};
        vecs[3] = '{"LDI",  16'h1805, 7'b000_00_0_0, 7'b100_01_0_0, 1'b0};
        vecs[4] = '{"ADD",  16'h2007, 7'b001_00_0_0, 7'b100_10_0_0, 1'b0};
        vecs[5] = '{"ADDI", 16'h2803, 7'b000_00_0_0, 7'b100_10_1_0, 1'b0};
        vecs[6] = '{"SUB",  16'h3005, 7'b001_00_0_0, 7'b100_10_0_1, 1'b0};
        vecs[7] = '{"SUBI", 16'h3809, 7'b000_00_0_0, 7'b100_10_1_1, 1'b0};
        vecs[8] = '{"ILL1F",16'hF800, 7'b000_00_0_0, 7'b000_00_0_0, 1'b0};
        vecs[9] = '{"ILL08",16'h4000, 7'b000_00_0_0, 7'b000_00_0_0, 1'b0};
        clear_mem(16'h0000);
        @(posedge clk);
        #1;
        check("reset outputs", {pc, operand, strb(), halt, cnt[11:0]}, 0);
        for (int i = 0; i < 10; i++) begin
            clear_mem(16'h0000);
            mem[0] = vecs[i].instr;
            reset_and_start();
            tick();
            check({vecs[i].name, " decode"}, {strb(), 5'b0, operand}, {vecs[i].dec, 5'b0, vecs[i].instr[10:0]});
            tick();
            check({vecs[i].name, " exec"}, {strb(), 5'b0, operand}, {vecs[i].exe, 5'b0, vecs[i].instr[10:0]});
            tick();
            check({vecs[i].name, " after"}, {halt, pc, strb()},
                  {vecs[i].hlt, vecs[i].hlt ? 11'd0 : 11'd1, 3'b000, vecs[i].exe[3:0]});
        end
        clear_mem(16'h0000);
        mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0810; mem[3] = 16'h0000;
        reset_and_start();
        check("prog1 fetch", {halt, pc, strb(), cnt[11:0]}, 0);
        run_instr("prog1 LDI", 7'b000_00_0_0, 7'b100_01_0_0);
        run_instr("prog1 ADDI", 7'b000_01_0_0, 7'b100_10_1_0);
        tick();
        tick();
        check("prog1 STO exec", {strb(), 5'b0, operand}, {7'b010_10_1_0, 16'h0010});
        tick();
        run_instr("prog1 HLT", 7'b000_10_1_0, 7'b000_10_1_0);
        check("prog1 halt", {halt, pc, cnt}, {1'b1, 11'd3, 32'd12});
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("prog1 halt hold", {halt, pc, strb(), cnt}, {1'b1, 11'd3, 7'b000_10_1_0, 32'd12});
        clear_mem(16'h0000);
        mem[0] = 16'h1004; mem[1] = 16'h3005;
        reset_and_start();
        tick();
        check("prog2 LD decode", {strb(), 5'b0, operand}, {7'b001_00_0_0, 16'h0004});
        tick();
        check("prog2 LD exec", 32'(strb()), 32'(7'b100_00_0_0));
        tick();
        check("prog2 LD width", 32'(strb()), 32'(7'b000_00_0_0));
        run_instr("prog2 SUB", 7'b001_00_0_0, 7'b100_10_0_1);
        check("prog2 SUB width", {pc, strb()}, {11'd2, 7'b000_10_0_1});
        clear_mem(16'h0000);
        mem[0] = 16'hF800;
        reset_and_start();
        run_instr("prog3 ILL", 7'b000_00_0_0, 7'b000_00_0_0);
        check("prog3 pc", {halt, pc}, {1'b0, 11'd1});
        run_instr("prog3 HLT", 7'b000_00_0_0, 7'b000_00_0_0);
        check("prog3 halt", {halt, pc, cnt}, {1'b1, 11'd1, 32'd6});
        clear_mem(16'h4000);
        reset_and_start();
        repeat (2047 * 3) tick();
        check("wrap top", {halt, pc, cnt}, {1'b0, 11'h7FF, 32'd6141});
        repeat (3) tick();
        check("wrap zero", {halt, pc, cnt}, {1'b0, 11'h000, 32'd6144});
        run_instr("wrap continue", 7'b000_00_0_0, 7'b000_00_0_0);
        check("wrap next", {halt, pc}, {1'b0, 11'd1});
        clear_mem(16'h0000);
        mem[0] = 16'h2007;
        reset_and_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start ignored decode", 32'(strb()), 32'(7'b001_00_0_0));
        tick();
        check("abort exec", 32'(strb()), 32'(7'b100_10_0_0));
        #2 rst = 1'b1;
        #1;
        check("abort async", {halt, pc, operand, strb()}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) tick();
        check("abort idle", {halt, pc, strb(), cnt}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
